// File: rtl/sinw_pkg.sv
// Constants shared by the sine-wave generator blocks: data widths, the CORDIC
// gain-compensated amplitude and the quarter/half-circle phase points.
package sinw_pkg;

    localparam int W    = 17;
    localparam int PW   = 16;
    localparam int AMPL = 19898;

    localparam logic [PW-1:0] PHASE_90  = 16'h4000;
    localparam logic [PW-1:0] PHASE_180 = 16'h8000;

    function automatic logic [W-1:0] sext_phase(input logic [PW-1:0] v);
        return {{(W-PW){v[PW-1]}}, v};
    endfunction

endpackage

// File: rtl/quad_fold.sv
// Folds a full-circle phase into the rotator convergence range [-90deg, +90deg),
// flipping the sign of the amplitude for the two left-half quadrants.
module quad_fold
    import sinw_pkg::*;
(
    input  logic [PW-1:0] p_i,
    output logic [W-1:0]  x_o,
    output logic [W-1:0]  z_o
);

    localparam logic [W-1:0] AMPL_W = W'(AMPL);

    logic [1:0]    quad;
    logic [PW-1:0] p_shift;

    assign quad    = p_i[PW-1:PW-2];
    assign p_shift = p_i - PHASE_180;

    always_comb begin
        x_o = AMPL_W;
        z_o = sext_phase(p_i);
        // Quadrants 1 and 2 rotate by 180deg, which negates the amplitude.
        if (quad == 2'd1 || quad == 2'd2) begin
            x_o = -AMPL_W;
            z_o = sext_phase(p_shift);
        end
    end

endmodule

// File: rtl/cordic_phase_gen.sv
// Phase accumulator with sample-rate divider and shadowed tuning word; emits
// folded rotator inputs through a valid/ready slot with a sticky overrun flag.
module cordic_phase_gen
    import sinw_pkg::*;
#(
    parameter int DIV = 4
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          en_i,
    input  logic [15:0]   ftw_i,
    input  logic          ftw_load_i,
    input  logic          sync_i,
    output logic [W-1:0]  x_o,
    output logic [W-1:0]  y_o,
    output logic [W-1:0]  z_o,
    output logic          valid_o,
    input  logic          ready_i,
    output logic          overrun_o
);

    localparam logic [15:0] DIV_LAST = 16'(DIV - 1);

    logic [15:0]   div_cnt_q, div_cnt_d;
    logic [PW-1:0] phase_q, phase_d;
    logic [15:0]   ftw_q, ftw_d;
    logic [15:0]   ftw_sh_q, ftw_sh_d;
    logic [W-1:0]  x_q, x_d;
    logic [W-1:0]  z_q, z_d;
    logic          valid_q, valid_d;
    logic          overrun_q, overrun_d;

    logic          tick;
    logic          slot_free;
    logic [W-1:0]  fold_x;
    logic [W-1:0]  fold_z;

    quad_fold u_fold (
        .p_i (phase_q),
        .x_o (fold_x),
        .z_o (fold_z)
    );

    assign tick      = en_i && (div_cnt_q == DIV_LAST) && !sync_i;
    assign slot_free = !valid_q || ready_i;

    always_comb begin
        div_cnt_d = div_cnt_q;
        phase_d   = phase_q;
        ftw_d     = ftw_q;
        ftw_sh_d  = ftw_sh_q;
        x_d       = x_q;
        z_d       = z_q;
        valid_d   = valid_q;
        overrun_d = overrun_q;

        if (sync_i) begin
            div_cnt_d = '0;
            phase_d   = '0;
        end else if (en_i) begin
            div_cnt_d = tick ? 16'd0 : div_cnt_q + 16'd1;
        end

        if (ftw_load_i) begin
            ftw_sh_d = ftw_i;
        end

        // The sample is the pre-increment phase; the increment uses the old FTW.
        if (tick) begin
            ftw_d   = ftw_load_i ? ftw_i : ftw_sh_q;
            phase_d = phase_q + ftw_q;
        end

        if (tick && slot_free) begin
            x_d     = fold_x;
            z_d     = fold_z;
            valid_d = 1'b1;
        end else if (tick) begin
            overrun_d = 1'b1;
        end else if (valid_q && ready_i) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            div_cnt_q <= '0;
            phase_q   <= '0;
            ftw_q     <= '0;
            ftw_sh_q  <= '0;
            x_q       <= '0;
            z_q       <= '0;
            valid_q   <= 1'b0;
            overrun_q <= 1'b0;
        end else begin
            div_cnt_q <= div_cnt_d;
            phase_q   <= phase_d;
            ftw_q     <= ftw_d;
            ftw_sh_q  <= ftw_sh_d;
            x_q       <= x_d;
            z_q       <= z_d;
            valid_q   <= valid_d;
            overrun_q <= overrun_d;
        end
    end

    assign x_o       = x_q;
    assign y_o       = '0;
    assign z_o       = z_q;
    assign valid_o   = valid_q;
    assign overrun_o = overrun_q;

endmodule

// File: tb/tb_cordic_phase_gen.sv
// Directed bench for cordic_phase_gen: a DIV=4 instance for phase walk, FTW,
// backpressure and sync/reset cases, and a DIV=1 instance for back-to-back.
module tb_cordic_phase_gen;

    localparam logic [16:0] XP = 17'h04DBA;
    localparam logic [16:0] XN = 17'h1B246;

    logic        clk = 1'b0;
    logic        rst;
    logic        en;
    logic [15:0] ftw;
    logic        ftw_load;
    logic        sync;
    logic        ready;

    logic [16:0] x, y, z;
    logic        valid, overrun;
    logic [16:0] x1, y1, z1;
    logic        valid1, overrun1;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc;

    logic [16:0] zt [17];
    logic [16:0] xt [17];

    always #5 clk = ~clk;

    cordic_phase_gen #(.DIV(4)) dut (
        .clk(clk), .rst(rst), .en_i(en), .ftw_i(ftw), .ftw_load_i(ftw_load),
        .sync_i(sync), .x_o(x), .y_o(y), .z_o(z), .valid_o(valid),
        .ready_i(ready), .overrun_o(overrun)
    );

    cordic_phase_gen #(.DIV(1)) dut1 (
        .clk(clk), .rst(rst), .en_i(en), .ftw_i(ftw), .ftw_load_i(ftw_load),
        .sync_i(sync), .x_o(x1), .y_o(y1), .z_o(z1), .valid_o(valid1),
        .ready_i(ready), .overrun_o(overrun1)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [16:0] obs, input logic [16:0] exp);
        n_checks++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic next_sample(output int c);
        c = 0;
        do begin
            step();
            c++;
        end while (valid !== 1'b1 && c < 20);
        check("sample_valid", {16'd0, valid}, 17'd1);
    endtask

    initial begin
        zt = '{17'h00000, 17'h01000, 17'h02000, 17'h03000,
               17'h1C000, 17'h1D000, 17'h1E000, 17'h1F000,
               17'h00000, 17'h01000, 17'h02000, 17'h03000,
               17'h1C000, 17'h1D000, 17'h1E000, 17'h1F000,
               17'h00000};
        xt = '{XP, XP, XP, XP, XN, XN, XN, XN,
               XN, XN, XN, XN, XP, XP, XP, XP, XP};

        rst = 1'b0; en = 1'b0; ftw = '0; ftw_load = 1'b0; sync = 1'b0; ready = 1'b0;
        repeat (3) step();
        check("rst_x", x, 17'd0);
        check("rst_y", y, 17'd0);
        check("rst_z", z, 17'd0);
        check("rst_valid", {16'd0, valid}, 17'd0);
        check("rst_overrun", {16'd0, overrun}, 17'd0);

        rst = 1'b1;
        for (int i = 0; i < 5; i++) begin
            step();
            check("idle_valid", {16'd0, valid}, 17'd0);
        end

        // Transfer FTW 0x1000 into ftw_q via one tick, then restart the phase.
        ftw = 16'h1000; ftw_load = 1'b1; en = 1'b1; ready = 1'b1;
        step();
        ftw_load = 1'b0;
        next_sample(cyc);
        sync = 1'b1;
        step();
        sync = 1'b0;
        next_sample(cyc);
        check("walk0_x", x, xt[0]);
        check("walk0_z", z, zt[0]);
        check("walk0_y", y, 17'd0);
        for (int k = 1; k <= 16; k++) begin
            next_sample(cyc);
            check("walk_period", 17'(cyc), 17'd4);
            check("walk_x", x, xt[k]);
            check("walk_z", z, zt[k]);
        end

        // Load between ticks: phase now 0x1000, ftw_q 0x1000.
        ftw = 16'h2000; ftw_load = 1'b1;
        step();
        ftw_load = 1'b0;
        next_sample(cyc);
        check("ftw_s1_z", z, 17'h01000);
        next_sample(cyc);
        check("ftw_s2_z", z, 17'h02000);
        next_sample(cyc);
        check("ftw_s3_x", x, XN);
        check("ftw_s3_z", z, 17'h1C000);
        next_sample(cyc);
        check("ftw_s4_z", z, 17'h1E000);

        // Load on the tick cycle itself: phase 0x8000, ftw_q 0x2000, div_cnt 0.
        repeat (3) step();
        ftw = 16'h0400; ftw_load = 1'b1;
        step();
        ftw_load = 1'b0;
        check("byp_valid", {16'd0, valid}, 17'd1);
        check("byp_s1_z", z, 17'h00000);
        next_sample(cyc);
        check("byp_s2_z", z, 17'h02000);
        next_sample(cyc);
        check("byp_s3_x", x, XN);
        check("byp_s3_z", z, 17'h02400);

        // Backpressure: slot empties, then ready held low for 10 clocks.
        step();
        ready = 1'b0;
        for (int i = 1; i <= 10; i++) begin
            step();
            check("bp_overrun", {16'd0, overrun}, (i >= 7) ? 17'd1 : 17'd0);
            if (i >= 3) begin
                check("bp_valid", {16'd0, valid}, 17'd1);
                check("bp_z_hold", z, 17'h02800);
            end
        end
        ready = 1'b1;
        step();
        check("bp_rel_valid", {16'd0, valid}, 17'd1);
        check("bp_rel_z", z, 17'h03000);
        check("bp_rel_x", x, XN);

        // Sync on a tick cycle suppresses the sample and restarts at phase 0.
        repeat (3) step();
        sync = 1'b1;
        step();
        sync = 1'b0;
        check("sync_no_sample", {16'd0, valid}, 17'd0);
        next_sample(cyc);
        check("sync_period", 17'(cyc), 17'd4);
        check("sync_z", z, 17'h00000);
        check("sync_x", x, XP);
        check("sync_overrun_sticky", {16'd0, overrun}, 17'd1);

        // Reset during a stalled handshake.
        ready = 1'b0; rst = 1'b0;
        step();
        check("midrst_valid", {16'd0, valid}, 17'd0);
        check("midrst_z", z, 17'd0);
        check("midrst_overrun", {16'd0, overrun}, 17'd0);
        rst = 1'b1; ready = 1'b1;

        // DIV=1 back-to-back: load on first tick bypasses to ftw_q.
        ftw = 16'h0100; ftw_load = 1'b1;
        step();
        ftw_load = 1'b0;
        for (int i = 2; i <= 10; i++) begin
            step();
            check("b2b_valid", {16'd0, valid1}, 17'd1);
            check("b2b_z", z1, 17'((i - 2) * 256));
            check("b2b_x", x1, XP);
            check("b2b_overrun", {16'd0, overrun1}, 17'd0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/cordic_phase_gen.md
Name: cordic_phase_gen

Overview:
- Upstream feeder for the CORDIC `rotator` in the sine-wave generator.
- Contains a 16-bit phase accumulator driven by a frequency tuning word (FTW) and a programmable sample-rate divider.
- Folds each phase sample into the rotator's convergence range and emits the rotator inputs: x = ±gain-compensated amplitude, y = 0, z = folded angle.
- Output uses a valid/ready handshake, with a sticky overrun flag.

Parameters:
- W, 17, width of x/y/z data (matches rotator x_i/y_i/z_i).
- PW, 16, phase accumulator width; full circle = 2^PW.
- DIV, 4, clocks per sample tick (legal range 1..65535).
- AMPL, 19898, initial x magnitude = round(0.60725·2^15); cancels CORDIC gain.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous reset, active-low
- en_i  in  1  enable; low freezes divider and tick generation
- ftw_i  in  16  frequency tuning word
- ftw_load_i  in  1  capture ftw_i into shadow register
- sync_i  in  1  phase restart (phase←0, divider←0)
- x_o  out  W  rotator x_i
- y_o  out  W  rotator y_i (always 0 when valid)
- z_o  out  W  rotator z_i, signed angle; 90° = 2^14
- valid_o  out  1  sample on x_o/y_o/z_o is valid
- ready_i  in  1  downstream accepts the sample
- overrun_o  out  1  sticky: a tick found the output slot occupied

Behaviour:
- Reset (rst=0 at posedge): phase_q=0, ftw_q=0, ftw_sh=0, div_cnt=0, x_o=y_o=z_o=0, valid_o=0, overrun_o=0. Reset overrides every other input, including mid-handshake.
- Divider:
  - When en_i=1, div_cnt counts 0..DIV-1; the tick occurs in the cycle where div_cnt==DIV-1 and en_i=1, then div_cnt←0.
  - When en_i=0, div_cnt holds.
  - DIV=1 gives a tick on every enabled cycle.
- Shadow FTW: ftw_load_i=1 ⇒ ftw_sh←ftw_i. ftw_q updates only on a tick: ftw_q ← (ftw_load_i ? ftw_i : ftw_sh).
- On a tick:
  - phase_q ← phase_q + ftw_q (old ftw_q), modulo 2^16, wrap silent.
  - The sample is taken from the pre-increment phase_q.
  - Phase is therefore continuous across FTW changes; a new FTW first affects the increment after the tick that loads it.
- Fold (combinational on p=phase_q; q=p[15:14]):
  - q=1 or q=2: x = −AMPL, z = sext(p − 2^15).
  - q=0 or q=3: x = +AMPL, z = sext(p as signed 16).
  - Resulting z range is [−2^14, 2^14) (±90°); y = 0.
  - Sign extension is to W bits.
- Output slot:
  - The slot is free when valid_o=0 or ready_i=1.
  - Tick with slot free: register x_o/y_o/z_o and set valid_o=1 in the next cycle (latency 1 clock from tick).
  - Tick with slot occupied: sample dropped, outputs held, phase still advances, overrun_o←1 (sticky until reset).
  - Handshake completes when valid_o & ready_i. With no new tick in that cycle, valid_o←0. A tick in the same cycle loads the new sample back-to-back with no overrun.
  - While valid_o=1 and ready_i=0, x_o/y_o/z_o are stable.
- sync_i=1:
  - phase_q←0, div_cnt←0; the tick in that cycle is suppressed (no sample, no FTW transfer).
  - The pending output sample and ftw_sh are unaffected.
  - sync_i has priority over en_i and tick.
- en_i falling with a valid sample pending: the handshake still completes normally.

Decomposition:
- Shared package (sinw_pkg): W, PW, AMPL, PHASE_90=16'h4000, PHASE_180=16'h8000. The rotator testbench reuses the same constants.
- One combinational sub-module, quad_fold (p → x, z), used by this block and reusable by the testbench reference model.
- The divider, accumulator and handshake stay in the top module.

Test Plan:
- Reset/idle: hold rst=0 for 3 clks, then release with en_i=0 → all outputs 0, valid_o never rises.
- Phase walk: DIV=4, load ftw=0x1000, pulse sync_i, en_i=1, ready_i=1.
  - Successive samples at phases 0x0000, 0x1000, …
  - 0x3000: x=19898, z=0x03000.
  - 0x4000: x=−19898, z=−16384 (17'h1C000).
  - 0x8000: x=−19898, z=0.
  - 0xC000: x=19898, z=−16384.
  - Phase wraps 0xF000→0x0000. Ticks are exactly 4 clks apart.
- FTW change: ftw=0x1000, then ftw_load_i with 0x2000 between ticks → next sample +0x1000, following samples +0x2000. Load coinciding with a tick → bypass takes effect on that tick.
- Backpressure: ready_i=0 for 10 clks at DIV=4 → outputs frozen on the first sample, overrun_o=1 after the second tick. Release ready → the next sample reflects a phase advanced by all elapsed ticks.
- Back-to-back: DIV=1, ready_i=1 → valid_o continuously high, new sample every clk, overrun_o stays 0.
- sync/reset mid-operation: sync_i asserted on a tick cycle → no sample that cycle, next sample phase=0. rst=0 while valid_o=1 & ready_i=0 → valid_o=0 next clk.
